// File: rtl/redcim_feeder_pkg.sv
// Shared types and BF16 constants for the redcim feeder block.
package redcim_feeder_pkg;

  localparam int BF16_SIGN_W = 1;
  localparam int BF16_EXP_W  = 8;
  localparam int BF16_MAN_W  = 7;
  localparam int BF16_W      = BF16_SIGN_W + BF16_EXP_W + BF16_MAN_W;

  localparam logic [BF16_W-1:0] BF16_ZERO = 16'h0000;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_LAUNCH,
    ST_WAIT,
    ST_HOLD
  } state_e;

  // A BF16 value with a zero exponent field is zero or denormal; treated as zero.
  function automatic logic bf16_exp_zero(input logic [BF16_W-1:0] v);
    return v[BF16_MAN_W +: BF16_EXP_W] == '0;
  endfunction

endpackage

// File: rtl/redcim_lane_packer.sv
// Lane counter and operand packing for the redcim feeder.
// With REDCIM_FEEDER_ZERO_SKIP_EN defined it also tracks whether every lane
// of the vector being filled is zero.
module redcim_lane_packer
  import redcim_feeder_pkg::*;
#(
  parameter int SIZE = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_wr,
  input  logic [BF16_W-1:0]      i_a,
  input  logic [BF16_W-1:0]      i_b,
  output logic                   o_last,
`ifdef REDCIM_FEEDER_ZERO_SKIP_EN
  output logic                   o_all_zero,
`endif
  output logic [BF16_W*SIZE-1:0] o_a,
  output logic [BF16_W*SIZE-1:0] o_b
);

  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;

  logic [CW-1:0]                 r_cnt;
  logic [SIZE-1:0][BF16_W-1:0]   r_a;
  logic [SIZE-1:0][BF16_W-1:0]   r_b;

  assign o_last = (r_cnt == CW'(SIZE - 1));
  assign o_a    = r_a;
  assign o_b    = r_b;

  // Lane pointer: advances per accepted pair, wraps to 0 after the last lane.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_cnt <= '0;
    else if (i_wr) r_cnt <= o_last ? '0 : r_cnt + 1'b1;
  end

  for (genvar g = 0; g < SIZE; g++) begin : g_lane
    // Lane g captures the pair accepted while the pointer sits on it.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_a[g] <= BF16_ZERO;
        r_b[g] <= BF16_ZERO;
      end else if (i_wr && r_cnt == CW'(g)) begin
        r_a[g] <= i_a;
        r_b[g] <= i_b;
      end
    end
  end

`ifdef REDCIM_FEEDER_ZERO_SKIP_EN
  logic r_allz;
  logic w_lane_zero;

  assign w_lane_zero = bf16_exp_zero(i_a) | bf16_exp_zero(i_b);
  // True on the accepting cycle when this lane and all earlier lanes are zero.
  assign o_all_zero  = w_lane_zero && (r_cnt == '0 || r_allz);

  // Running all-zero flag for the lanes already written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_allz <= 1'b0;
    else if (i_wr) r_allz <= o_all_zero;
  end
`endif

endmodule

// File: rtl/redcim_feeder.sv
// Operand feeder for a CIM dot-product core: packs SIZE BF16 pairs, launches
// the core, waits CORE_LAT cycles, and holds the result until it is taken.
// Optional macro REDCIM_FEEDER_ZERO_SKIP_EN: all-zero vectors bypass the core.
module redcim_feeder
  import redcim_feeder_pkg::*;
#(
  parameter int SIZE     = 2,
  parameter int CORE_LAT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BF16_W-1:0]      in_a,
  input  logic [BF16_W-1:0]      in_b,
  output logic                   core_start,
  output logic [BF16_W*SIZE-1:0] core_A,
  output logic [BF16_W*SIZE-1:0] core_B,
  input  logic [BF16_W-1:0]      core_out,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [BF16_W-1:0]      res_data,
  output logic [15:0]            res_cnt
);

  localparam int LW = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;

  state_e            r_state, w_next;
  logic [LW-1:0]     r_lat;
  logic [BF16_W-1:0] r_res_data;
  logic [15:0]       r_res_cnt;
  logic              w_acc, w_last, w_lat_done, w_skip;

  assign w_acc      = in_valid && (r_state == ST_FILL);
  assign w_lat_done = (r_lat == LW'(CORE_LAT - 1));
  assign res_data   = r_res_data;
  assign res_cnt    = r_res_cnt;

  redcim_lane_packer #(.SIZE(SIZE)) u_packer (
    .clk        (clk),
    .rst        (rst),
    .i_wr       (w_acc),
    .i_a        (in_a),
    .i_b        (in_b),
    .o_last     (w_last),
`ifdef REDCIM_FEEDER_ZERO_SKIP_EN
    .o_all_zero (w_skip),
`endif
    .o_a        (core_A),
    .o_b        (core_B)
  );

`ifndef REDCIM_FEEDER_ZERO_SKIP_EN
  assign w_skip = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_FILL;
    else     r_state <= w_next;
  end

  // Next-state and handshake/launch outputs.
  always_comb begin
    w_next     = r_state;
    in_ready   = 1'b0;
    core_start = 1'b0;
    res_valid  = 1'b0;
    case (r_state)
      ST_FILL: begin
        in_ready = 1'b1;
        if (w_acc && w_last) w_next = w_skip ? ST_HOLD : ST_LAUNCH;
      end
      ST_LAUNCH: begin
        core_start = 1'b1;
        w_next     = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_lat_done) w_next = ST_HOLD;
      end
      ST_HOLD: begin
        res_valid = 1'b1;
        if (res_ready) w_next = ST_FILL;
      end
      default: w_next = ST_FILL;
    endcase
  end

  // Core latency counter: counts WAIT cycles, idle at 0 elsewhere.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   r_lat <= '0;
    else if (r_state == ST_WAIT) r_lat <= r_lat + 1'b1;
    else                       r_lat <= '0;
  end

  // Result capture: core output at the end of the last WAIT cycle, or zero on skip.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                r_res_data <= BF16_ZERO;
    else if (r_state == ST_WAIT && w_lat_done) r_res_data <= core_out;
    else if (w_acc && w_last && w_skip)     r_res_data <= BF16_ZERO;
  end

  // Delivered-result counter, free-running 16-bit wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                r_res_cnt <= '0;
    else if (r_state == ST_HOLD && res_ready) r_res_cnt <= r_res_cnt + 16'd1;
  end

endmodule

// File: tb/tb_redcim_feeder.sv
// Directed table-driven bench for redcim_feeder (SIZE=2, CORE_LAT=4).
module tb_redcim_feeder;

  localparam int SIZE     = 2;
  localparam int CORE_LAT = 4;

`ifdef REDCIM_FEEDER_ZERO_SKIP_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  logic              clk, rst, in_valid, in_ready, core_start, res_valid, res_ready;
  logic [15:0]       in_a, in_b, core_out, res_data, res_cnt;
  logic [16*SIZE-1:0] core_A, core_B;

  redcim_feeder #(.SIZE(SIZE), .CORE_LAT(CORE_LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .core_start(core_start), .core_A(core_A),
    .core_B(core_B), .core_out(core_out), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_cnt(res_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model: result valid only during the CORE_LAT-th cycle after launch.
  logic [CORE_LAT-1:0] core_pipe;
  logic [15:0]         core_val;
  always @(posedge clk or posedge rst) begin
    if (rst) core_pipe <= '0;
    else     core_pipe <= {core_pipe[CORE_LAT-2:0], core_start};
  end
  assign core_out = core_pipe[CORE_LAT-1] ? core_val : 16'hDEAD;

  typedef struct {
    logic [15:0] a0, b0, a1, b1, cv, res;
    logic [31:0] ea, eb;
    bit          skip;
  } vec_t;

  vec_t        vt[4];
  int          n_vec = 0, n_err = 0;
  logic [15:0] exp_cnt;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", n, act, exp, $time);
    end
  endtask

  task automatic run_vec(input vec_t v, input int hold, input bit stall);
    int lat, starts;
    res_ready = 1'b0;
    core_val  = v.cv;
    check("in_ready_fill", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_a = v.a0; in_b = v.b0;
    tick();
    if (stall) begin
      in_valid = 1'b0; in_a = 16'hFFFF; in_b = 16'hFFFF;
      repeat (2) tick();
      check("stall_no_start", {31'd0, core_start}, 32'd0);
      check("stall_ready", {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b1; in_a = v.a1; in_b = v.b1;
    tick();
    // Junk offered while busy must not be consumed.
    in_valid = 1'b1; in_a = 16'hAAAA; in_b = 16'h5555;
    check("core_A", core_A, v.ea);
    check("core_B", core_B, v.eb);
    if (v.skip) begin
      check("skip_valid", {31'd0, res_valid}, 32'd1);
      check("skip_no_start", {31'd0, core_start}, 32'd0);
    end else begin
      check("launch_start", {31'd0, core_start}, 32'd1);
      lat = 0; starts = 0;
      while (!res_valid && lat < 20) begin
        tick(); lat++;
        if (core_start) starts++;
      end
      check("latency", lat, CORE_LAT + 1);
      check("extra_start", starts, 0);
    end
    check("res_data", {16'd0, res_data}, {16'd0, v.res});
    check("in_ready_hold", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("bp_valid", {31'd0, res_valid}, 32'd1);
      check("bp_data", {16'd0, res_data}, {16'd0, v.res});
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_cnt", {16'd0, res_cnt}, {16'd0, exp_cnt});
    end
    check("hold_core_A", core_A, v.ea);
    in_valid = 1'b0; res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    check("res_cnt", {16'd0, res_cnt}, {16'd0, exp_cnt});
    check("valid_drop", {31'd0, res_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bit saw;
    vt[0] = '{a0:16'h3F80, b0:16'h4000, a1:16'h4040, b1:16'h3F80, cv:16'h40A0,
              res:16'h40A0, ea:32'h40403F80, eb:32'h3F804000, skip:1'b0};
    vt[1] = '{a0:16'h0000, b0:16'h41BF, a1:16'h4135, b1:16'h0000, cv:16'h1234,
              res:(ZS ? 16'h0000 : 16'h1234), ea:32'h41350000, eb:32'h000041BF, skip:ZS};
    vt[2] = '{a0:16'hC000, b0:16'h3F00, a1:16'h7F7F, b1:16'h0080, cv:16'hBEEF,
              res:16'hBEEF, ea:32'h7F7FC000, eb:32'h00803F00, skip:1'b0};
    vt[3] = '{a0:16'h0000, b0:16'h4000, a1:16'h4000, b1:16'h4000, cv:16'h4100,
              res:16'h4100, ea:32'h40000000, eb:32'h40004000, skip:1'b0};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; res_ready = 1'b0;
    core_val = '0; exp_cnt = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_core_start", {31'd0, core_start}, 32'd0);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_res_data", {16'd0, res_data}, 32'd0);
    check("rst_res_cnt", {16'd0, res_cnt}, 32'd0);
    check("rst_core_A", core_A, 32'd0);
    check("rst_core_B", core_B, 32'd0);
    rst = 1'b0;
    tick();

    // Table vectors.
    for (int i = 0; i < 4; i++) run_vec(vt[i], 0, 1'b0);

    // Backpressure: ten cycles of res_ready low.
    run_vec(vt[2], 10, 1'b0);

    // Operand stalls: in_valid 1,0,0,1.
    run_vec(vt[0], 0, 1'b1);

    // Reset two cycles after core_start.
    core_val = 16'h40A0;
    in_valid = 1'b1; in_a = 16'h3F80; in_b = 16'h4000; tick();
    in_a = 16'h4040; in_b = 16'h3F80; tick();
    in_valid = 1'b0;
    check("rw_launch", {31'd0, core_start}, 32'd1);
    repeat (2) tick();
    rst = 1'b1;
    #1;
    check("rw_valid", {31'd0, res_valid}, 32'd0);
    check("rw_start", {31'd0, core_start}, 32'd0);
    check("rw_core_A", core_A, 32'd0);
    check("rw_res_cnt", {16'd0, res_cnt}, 32'd0);
    #2 rst = 1'b0;
    exp_cnt = '0;
    saw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (res_valid || core_start) saw = 1'b1;
    end
    check("rw_quiet", {31'd0, saw}, 32'd0);
    run_vec(vt[0], 0, 1'b0);

    // Counter wrap: preset near the top, then deliver two results.
    force dut.r_res_cnt = 16'hFFFE;
    tick();
    release dut.r_res_cnt;
    tick();
    exp_cnt = 16'hFFFE;
    check("wrap_preset", {16'd0, res_cnt}, 32'h0000FFFE);
    run_vec(vt[0], 0, 1'b0);
    run_vec(vt[2], 0, 1'b0);
    check("wrap_zero", {16'd0, res_cnt}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
